// File: rtl/apb_master_ctrl.sv
// APB master controller: turns single-cycle user strobes into APB SETUP/ACCESS
// transfers with wait-state timeout, slave-error reporting and back-to-back issue.
module apb_master_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              transfer,
  input  logic              read_write,
  input  logic [ADDR_W-1:0] apb_write_paddr,
  input  logic [DATA_W-1:0] apb_write_data,
  input  logic [ADDR_W-1:0] apb_read_paddr,
  output logic [DATA_W-1:0] apb_read_data_out,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata,
  output logic              busy,
  output logic              done,
  output logic              slv_err,
  output logic              timeout_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_t            state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              slv_err_q, slv_err_d;
  logic              timeout_err_q, timeout_err_d;
  logic              latch_cmd;

  // Handshake: a user command is accepted on any edge where transfer=1 and the
  // FSM is in IDLE or completing ACCESS; an APB beat completes on the edge where
  // psel & penable & pready are all high. pready outside ACCESS means nothing.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rdata_d       = rdata_q;
    done_d        = 1'b0;
    slv_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    latch_cmd     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          state_d   = SETUP;
          latch_cmd = 1'b1;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          done_d    = 1'b1;
          slv_err_d = pslverr;
          if (!pwrite_q && !pslverr) rdata_d = prdata;
          if (transfer) begin
            state_d   = SETUP;
            latch_cmd = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (wait_cnt_q == TIMEOUT_LIM) begin
          state_d       = IDLE;
          done_d        = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (latch_cmd) begin
      wait_cnt_d = '0;
      pwrite_d   = !read_write;
      paddr_d    = read_write ? apb_read_paddr : apb_write_paddr;
      if (!read_write) pwdata_d = apb_write_data;
    end

    // Bus controls are decoded from the next state so they leave the flops aligned with it.
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge pclk) begin
    if (!preset) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      slv_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rdata_q       <= rdata_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      slv_err_q     <= slv_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign psel              = psel_q;
  assign penable           = penable_q;
  assign pwrite            = pwrite_q;
  assign paddr             = paddr_q;
  assign pwdata            = pwdata_q;
  assign apb_read_data_out = rdata_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign slv_err           = slv_err_q;
  assign timeout_err       = timeout_err_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: driver tasks push expected completions
// into a queue, a monitor pops and compares on every done pulse.
module tb_apb_master_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int EXP_W  = DATA_W + 2;

  logic              pclk = 1'b0;
  logic              preset = 1'b0;
  logic              transfer = 1'b0;
  logic              read_write = 1'b0;
  logic [ADDR_W-1:0] apb_write_paddr = '0;
  logic [DATA_W-1:0] apb_write_data = '0;
  logic [ADDR_W-1:0] apb_read_paddr = '0;
  logic [DATA_W-1:0] apb_read_data_out;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready = 1'b0;
  logic              pslverr = 1'b0;
  logic [DATA_W-1:0] prdata = '0;
  logic              busy, done, slv_err, timeout_err;
  logic [1:0]        dbg_state;

  apb_master_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(4)) dut (
    .pclk(pclk), .preset(preset), .transfer(transfer), .read_write(read_write),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata), .busy(busy), .done(done),
    .slv_err(slv_err), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  // scoreboard state: {timeout_err, slv_err, apb_read_data_out}
  logic [EXP_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] exp_rdata = '0;
  int                pass_cnt = 0;
  int                tot_cnt  = 0;

  // slave configuration
  int                slv_waits = 0;
  logic              slv_err_cfg = 1'b0;
  logic [DATA_W-1:0] slv_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // slave model: answers after slv_waits not-ready ACCESS cycles
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        pready  = (acc_cnt == slv_waits);
        pslverr = pready ? slv_err_cfg : 1'b0;
        acc_cnt++;
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
        acc_cnt = 0;
      end
      prdata = slv_rdata;
    end
  end

  // monitor
  initial begin
    logic [EXP_W-1:0] exp;
    forever begin
      @(negedge pclk);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {timeout_err, slv_err, apb_read_data_out}, '1);
        end else begin
          exp = exp_q.pop_front();
          check("completion", {timeout_err, slv_err, apb_read_data_out}, exp);
        end
      end else if (slv_err || timeout_err) begin
        check("err_without_done", {timeout_err, slv_err}, 2'b00);
      end
    end
  end

  // driver tasks
  task automatic issue(input logic rw, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata);
    @(negedge pclk);
    transfer        = 1'b1;
    read_write      = rw;
    apb_write_paddr = rw ? 8'h00 : addr;
    apb_write_data  = wdata;
    apb_read_paddr  = rw ? addr : 8'h00;
    @(posedge pclk);
    #1 transfer = 1'b0;
  endtask

  task automatic run_until_done(input string name, output int pen_cycles);
    bit seen;
    seen = 1'b0;
    pen_cycles = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge pclk);
      if (done) seen = 1'b1;
      else if (penable) pen_cycles++;
    end
    if (!seen) check({name, "_done_timeout"}, 0, 1);
  endtask

  initial begin
    int pen;

    // reset
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("reset_outputs", {psel, penable, pwrite, busy, done, slv_err, timeout_err,
                            paddr, pwdata, apb_read_data_out, dbg_state}, 0);
    preset = 1'b1;

    // write, zero wait: latency psel N+1, penable N+2, done N+3
    slv_waits = 0; slv_err_cfg = 1'b0; slv_rdata = 8'h00;
    exp_q.push_back({2'b00, exp_rdata});
    issue(1'b0, 8'h12, 8'hA5);
    @(negedge pclk);
    check("wr_setup", {psel, penable, pwrite, busy, paddr, pwdata}, {4'b1011, 8'h12, 8'hA5});
    @(negedge pclk);
    check("wr_access", {psel, penable, pwrite, paddr, pwdata}, {3'b111, 8'h12, 8'hA5});
    @(negedge pclk);
    check("wr_done", {done, psel, penable, busy}, 4'b1000);

    // read, 3 wait states
    slv_waits = 3; slv_rdata = 8'h3C;
    exp_rdata = 8'h3C;
    exp_q.push_back({2'b00, exp_rdata});
    issue(1'b1, 8'h40, 8'h00);
    @(negedge pclk);
    check("rd_setup", {psel, penable, pwrite, paddr}, {3'b100, 8'h40});
    run_until_done("rd_wait", pen);
    check("rd_wait_penable_cycles", pen, 4);

    // back-to-back: write 0x05/0x11 then read 0x05, transfer held high
    slv_waits = 0;
    @(negedge pclk);
    transfer = 1'b1; read_write = 1'b0; apb_write_paddr = 8'h05; apb_write_data = 8'h11;
    exp_q.push_back({2'b00, exp_rdata});
    @(negedge pclk);
    read_write = 1'b1; apb_read_paddr = 8'h05; slv_rdata = 8'h11;
    exp_rdata = 8'h11;
    exp_q.push_back({2'b00, exp_rdata});
    @(negedge pclk);
    check("b2b_first_access", {penable, pwrite, paddr, pwdata}, {2'b11, 8'h05, 8'h11});
    @(negedge pclk);
    check("b2b_second_setup", {done, busy, psel, penable, pwrite, paddr}, {5'b11100, 8'h05});
    transfer = 1'b0;
    run_until_done("b2b_read", pen);
    check("b2b_read_penable_cycles", pen, 1);

    // slave error on read: data register keeps 0x11
    slv_err_cfg = 1'b1; slv_rdata = 8'hFF;
    exp_q.push_back({2'b01, exp_rdata});
    issue(1'b1, 8'h22, 8'h00);
    run_until_done("slverr", pen);
    slv_err_cfg = 1'b0;

    // timeout with TIMEOUT_CYC=4: five ACCESS cycles then abort
    slv_waits = 255; slv_rdata = 8'h77;
    exp_q.push_back({2'b10, exp_rdata});
    issue(1'b1, 8'h33, 8'h00);
    run_until_done("timeout", pen);
    check("timeout_penable_cycles", pen, 5);
    check("timeout_bus_idle", {psel, penable, busy}, 3'b000);
    @(negedge pclk);
    check("timeout_pulse_single", {done, timeout_err}, 2'b00);

    // reset during a wait state aborts silently
    issue(1'b0, 8'h44, 8'h66);
    repeat (3) @(negedge pclk);
    check("pre_reset_in_access", {psel, penable}, 2'b11);
    preset = 1'b0;
    @(negedge pclk);
    preset = 1'b1;
    exp_rdata = 8'h00;
    check("reset_mid_access", {psel, penable, pwrite, busy, done, slv_err, timeout_err,
                               paddr, pwdata, apb_read_data_out, dbg_state}, 0);
    repeat (4) @(negedge pclk);

    // new write, then read, complete normally after reset
    slv_waits = 0;
    exp_q.push_back({2'b00, exp_rdata});
    issue(1'b0, 8'h7E, 8'h99);
    @(negedge pclk);
    check("post_reset_wr_setup", {psel, pwrite, paddr, pwdata}, {2'b11, 8'h7E, 8'h99});
    run_until_done("post_reset_wr", pen);
    slv_rdata = 8'h5A;
    exp_rdata = 8'h5A;
    exp_q.push_back({2'b00, exp_rdata});
    issue(1'b1, 8'h7E, 8'h00);
    @(negedge pclk);
    check("read_keeps_pwdata", {pwrite, pwdata}, {1'b0, 8'h99});
    run_until_done("post_reset_rd", pen);

    repeat (5) @(negedge pclk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
